// File: rtl/rotate_addr_gen.sv
// rtl/rotate_addr_gen.sv - tile fill / rotate / drain address generator
// Optional source-column mirroring is compiled in with `define RAG_MIRROR_EN.
module rotate_addr_gen #(
    parameter int P_TILE  = 8,
    parameter int P_CH    = 3,
    parameter int P_LANES = 4,
    parameter int P_AW    = 8
) (
    input  logic                       I_RAG_HCLK,
    input  logic                       I_RAG_HRESET_N,
    input  logic                       I_RAG_START,
    input  logic [1:0]                 I_RAG_DEGREES,
    input  logic                       I_RAG_DIRECTION,
    input  logic                       I_RAG_BEAT_VALID,
`ifdef RAG_MIRROR_EN
    input  logic                       I_RAG_MIRROR,
`endif
    output logic [P_LANES*P_AW-1:0]    O_RAG_FILL_ADDR,
    output logic [P_CH*P_AW-1:0]       O_RAG_SRC_ADDR,
    output logic [P_CH*P_AW-1:0]       O_RAG_DST_ADDR,
    output logic                       O_RAG_ROT_VALID,
    output logic [P_LANES*P_AW-1:0]    O_RAG_DRAIN_ADDR,
    output logic                       O_RAG_BUSY,
    output logic                       O_RAG_DONE
);

    localparam int NBEAT = P_TILE * P_TILE * P_CH / P_LANES;
    localparam int CW    = $clog2(NBEAT + 1);
    localparam int RW    = $clog2(P_TILE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ROTATE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              k_q, k_d;
    logic [CW-1:0]           beat_cnt_q, beat_cnt_d;
    logic [P_AW-1:0]         fill_base_q, fill_base_d;
    logic [P_AW-1:0]         drain_base_q, drain_base_d;
    logic [RW-1:0]           row_q, row_d;
    logic [RW-1:0]           col_q, col_d;
    logic [P_CH*P_AW-1:0]    src_q, src_d;
    logic [P_CH*P_AW-1:0]    dst_q, dst_d;
    logic                    rot_valid_q, rot_valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    addr_load;
    logic                    mirror_en;

    int                      out_r, out_c;
    int                      src_r, src_c;

`ifdef RAG_MIRROR_EN
    logic                    mirror_q, mirror_d;

    // Mirror select is captured with the rotation settings and held for the tile.
    always_ff @(posedge I_RAG_HCLK) begin
        if (!I_RAG_HRESET_N) begin
            mirror_q <= 1'b0;
        end else begin
            mirror_q <= mirror_d;
        end
    end

    // Latch mirror only when a tile is accepted.
    always_comb begin
        mirror_d = mirror_q;
        if (state_q == S_IDLE && I_RAG_START) begin
            mirror_d = I_RAG_MIRROR;
        end
    end

    assign mirror_en = mirror_q;
`else
    assign mirror_en = 1'b0;
`endif

    // State, counters and registered outputs.
    always_ff @(posedge I_RAG_HCLK) begin
        if (!I_RAG_HRESET_N) begin
            state_q      <= S_IDLE;
            k_q          <= 2'd0;
            beat_cnt_q   <= '0;
            fill_base_q  <= '0;
            drain_base_q <= '0;
            row_q        <= '0;
            col_q        <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            rot_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            beat_cnt_q   <= beat_cnt_d;
            fill_base_q  <= fill_base_d;
            drain_base_q <= drain_base_d;
            row_q        <= row_d;
            col_q        <= col_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            rot_valid_q  <= rot_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Phase sequencing, beat counting and the row-major output pixel scan.
    // row/col hold the pixel whose addresses are currently registered, so the
    // first pixel is loaded on the same edge that leaves FILL.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        beat_cnt_d   = beat_cnt_q;
        fill_base_d  = fill_base_q;
        drain_base_d = drain_base_q;
        row_d        = row_q;
        col_d        = col_q;
        rot_valid_d  = 1'b0;
        addr_load    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (I_RAG_START) begin
                    state_d = S_FILL;
                    k_d     = I_RAG_DIRECTION ? (2'd0 - I_RAG_DEGREES) : I_RAG_DEGREES;
                end
            end
            S_FILL: begin
                if (I_RAG_BEAT_VALID) begin
                    if (beat_cnt_q == CW'(NBEAT - 1)) begin
                        state_d     = S_ROTATE;
                        beat_cnt_d  = '0;
                        fill_base_d = '0;
                        row_d       = '0;
                        col_d       = '0;
                        addr_load   = 1'b1;
                        rot_valid_d = 1'b1;
                    end else begin
                        beat_cnt_d  = beat_cnt_q + 1'b1;
                        fill_base_d = fill_base_q + P_AW'(P_LANES);
                    end
                end
            end
            S_ROTATE: begin
                if (row_q == RW'(P_TILE - 1) && col_q == RW'(P_TILE - 1)) begin
                    state_d = S_DRAIN;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    if (col_q == RW'(P_TILE - 1)) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    addr_load   = 1'b1;
                    rot_valid_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (I_RAG_BEAT_VALID) begin
                    if (beat_cnt_q == CW'(NBEAT - 1)) begin
                        state_d      = S_DONE;
                        beat_cnt_d   = '0;
                        drain_base_d = '0;
                    end else begin
                        beat_cnt_d   = beat_cnt_q + 1'b1;
                        drain_base_d = drain_base_q + P_AW'(P_LANES);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_FILL) || (state_d == S_ROTATE) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // Map the next output pixel to its clockwise-rotated source pixel and
    // expand both pixel indices to per-channel byte addresses.
    always_comb begin
        src_d = src_q;
        dst_d = dst_q;
        out_r = int'(row_d);
        out_c = int'(col_d);
        src_r = out_r;
        src_c = out_c;

        case (k_q)
            2'd1: begin
                src_r = P_TILE - 1 - out_c;
                src_c = out_r;
            end
            2'd2: begin
                src_r = P_TILE - 1 - out_r;
                src_c = P_TILE - 1 - out_c;
            end
            2'd3: begin
                src_r = out_c;
                src_c = P_TILE - 1 - out_r;
            end
            default: begin
                src_r = out_r;
                src_c = out_c;
            end
        endcase

        if (mirror_en) begin
            src_c = P_TILE - 1 - src_c;
        end

        if (addr_load) begin
            for (int ch = 0; ch < P_CH; ch++) begin
                src_d[ch*P_AW +: P_AW] = P_AW'(P_CH * (src_r * P_TILE + src_c) + ch);
                dst_d[ch*P_AW +: P_AW] = P_AW'(P_CH * (out_r * P_TILE + out_c) + ch);
            end
        end
    end

    // Lane i of each AHB beat addresses base + i.
    for (genvar i = 0; i < P_LANES; i++) begin : g_lane
        assign O_RAG_FILL_ADDR[i*P_AW +: P_AW]  = fill_base_q + P_AW'(i);
        assign O_RAG_DRAIN_ADDR[i*P_AW +: P_AW] = drain_base_q + P_AW'(i);
    end

    assign O_RAG_SRC_ADDR  = src_q;
    assign O_RAG_DST_ADDR  = dst_q;
    assign O_RAG_ROT_VALID = rot_valid_q;
    assign O_RAG_BUSY      = busy_q;
    assign O_RAG_DONE      = done_q;

endmodule

// File: tb/tb_rotate_addr_gen.sv
// tb/tb_rotate_addr_gen.sv - randomized self-checking bench for rotate_addr_gen
module tb_rotate_addr_gen;

    localparam int N   = 8;
    localparam int CH  = 3;
    localparam int L   = 4;
    localparam int AW  = 8;
    localparam int B   = N * N * CH / L;
    localparam int SN  = 4;
    localparam int SCH = 4;
    localparam int SL  = 8;
    localparam int SB  = SN * SN * SCH / SL;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rstn;
    logic              start, dir, bv;
    logic [1:0]        deg;
    logic [L*AW-1:0]   fill, drain;
    logic [CH*AW-1:0]  src, dst;
    logic              rv, busy, done;

    logic              s_start, s_dir, s_bv;
    logic [1:0]        s_deg;
    logic [SL*AW-1:0]  s_fill, s_drain;
    logic [SCH*AW-1:0] s_src, s_dst;
    logic              s_rv, s_busy, s_done;

    int n_vec = 0;
    int n_err = 0;

    rotate_addr_gen #(.P_TILE(N), .P_CH(CH), .P_LANES(L), .P_AW(AW)) u_dut (
        .I_RAG_HCLK(clk), .I_RAG_HRESET_N(rstn), .I_RAG_START(start),
        .I_RAG_DEGREES(deg), .I_RAG_DIRECTION(dir), .I_RAG_BEAT_VALID(bv),
        .O_RAG_FILL_ADDR(fill), .O_RAG_SRC_ADDR(src), .O_RAG_DST_ADDR(dst),
        .O_RAG_ROT_VALID(rv), .O_RAG_DRAIN_ADDR(drain), .O_RAG_BUSY(busy),
        .O_RAG_DONE(done)
    );

    rotate_addr_gen #(.P_TILE(SN), .P_CH(SCH), .P_LANES(SL), .P_AW(AW)) u_dut_small (
        .I_RAG_HCLK(clk), .I_RAG_HRESET_N(rstn), .I_RAG_START(s_start),
        .I_RAG_DEGREES(s_deg), .I_RAG_DIRECTION(s_dir), .I_RAG_BEAT_VALID(s_bv),
        .O_RAG_FILL_ADDR(s_fill), .O_RAG_SRC_ADDR(s_src), .O_RAG_DST_ADDR(s_dst),
        .O_RAG_ROT_VALID(s_rv), .O_RAG_DRAIN_ADDR(s_drain), .O_RAG_BUSY(s_busy),
        .O_RAG_DONE(s_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] lanes(input int base, input int nl);
        logic [63:0] v = '0;
        for (int i = 0; i < nl; i++) v[i*8 +: 8] = 8'(base + i);
        return v;
    endfunction

    function automatic logic [63:0] pix_addr(input int n, input int nch, input int r, input int c);
        logic [63:0] v = '0;
        for (int ch = 0; ch < nch; ch++) v[ch*8 +: 8] = 8'(nch * (r * n + c) + ch);
        return v;
    endfunction

    // Source of output (r,c) under k clockwise quarter turns: apply the
    // single quarter-turn pull-back (r,c) <- (n-1-c, r) k times.
    function automatic logic [63:0] src_exp(input int n, input int nch, input int k, input int r, input int c);
        int sr = r;
        int sc = c;
        int t;
        for (int i = 0; i < k; i++) begin
            t  = sr;
            sr = n - 1 - sc;
            sc = t;
        end
        return pix_addr(n, nch, sr, sc);
    endfunction

    function automatic logic pick_bv(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return cyc[0];
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_tile(input int d, input int di, input int mode, input bit hold);
        int k;
        int beats;
        int base;
        int cyc;
        k = di ? (4 - d) % 4 : d;
        chk("idle_busy", busy, 0);
        start = 1'b1; deg = 2'(d); dir = di[0]; bv = 1'b0;
        tick();
        if (!hold) start = 1'b0;
        deg = 2'($urandom); dir = 1'($urandom);
        chk("fill_busy", busy, 1);
        beats = 0; base = 0; cyc = 0;
        while (beats < B && cyc < 1000) begin
            chk("fill_addr", fill, lanes(base, L));
            chk("fill_drain_addr", drain, lanes(0, L));
            chk("fill_rv", rv, 0);
            chk("fill_done", done, 0);
            bv = pick_bv(mode, cyc);
            tick();
            if (bv) begin beats++; base += L; end
            cyc++;
        end
        chk("fill_beats", beats, B);
        for (int p = 0; p < N * N; p++) begin
            chk("rot_valid", rv, 1);
            chk("rot_src", src, src_exp(N, CH, k, p / N, p % N));
            chk("rot_dst", dst, pix_addr(N, CH, p / N, p % N));
            bv = 1'($urandom_range(0, 1));
            tick();
        end
        chk("rot_end_valid", rv, 0);
        chk("rot_hold_src", src, src_exp(N, CH, k, N - 1, N - 1));
        chk("rot_hold_dst", dst, pix_addr(N, CH, N - 1, N - 1));
        beats = 0; base = 0; cyc = 0;
        while (beats < B && cyc < 1000) begin
            chk("drain_addr", drain, lanes(base, L));
            chk("drain_fill_addr", fill, lanes(0, L));
            chk("drain_busy", busy, 1);
            chk("drain_done", done, 0);
            bv = pick_bv(mode, cyc);
            tick();
            if (bv) begin beats++; base += L; end
            cyc++;
        end
        chk("drain_beats", beats, B);
        bv = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_drain_addr", drain, lanes(0, L));
        tick();
        chk("done_clear", done, 0);
        chk("idle_after_done", busy, 0);
        if (hold) begin
            tick();
            chk("restart_busy", busy, 1);
            start = 1'b0;
            rstn = 1'b0;
            tick();
            rstn = 1'b1;
            chk("restart_rst_busy", busy, 0);
        end
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; deg = 2'd0; dir = 1'b0; bv = 1'b0;
        s_start = 1'b0; s_deg = 2'd0; s_dir = 1'b0; s_bv = 1'b0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_fill", fill, lanes(0, L));
        chk("rst_drain", drain, lanes(0, L));
        chk("rst_rv", rv, 0);
        chk("rst_src", src, 0);
        chk("rst_dst", dst, 0);
        chk("rst_done", done, 0);
        rstn = 1'b1;

        // Beats outside FILL/DRAIN must not move the bases.
        bv = 1'b1;
        repeat (3) tick();
        chk("idle_bv_fill", fill, lanes(0, L));
        chk("idle_bv_busy", busy, 0);
        bv = 1'b0;

        run_tile(1, 0, 0, 1'b0);
        run_tile(1, 1, 1, 1'b0);
        run_tile(2, 0, 2, 1'b0);
        run_tile(2, 1, 2, 1'b0);
        run_tile(0, 0, 1, 1'b0);
        for (int t = 0; t < 3; t++) run_tile(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), 2, 1'b0);
        run_tile(3, 0, 2, 1'b1);

        // Reset in the middle of ROTATE.
        start = 1'b1; deg = 2'd1; dir = 1'b0;
        tick();
        start = 1'b0; bv = 1'b1;
        repeat (B) tick();
        bv = 1'b0;
        repeat (5) tick();
        chk("mid_rot_valid", rv, 1);
        rstn = 1'b0;
        tick();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rv", rv, 0);
        chk("mid_rst_src", src, 0);
        chk("mid_rst_dst", dst, 0);
        chk("mid_rst_fill", fill, lanes(0, L));
        chk("mid_rst_done", done, 0);
        rstn = 1'b1;
        tick();
        chk("mid_rst_idle", busy, 0);

        // Small configuration: 4x4 tile, 4 channels, 8 lanes, k=3.
        s_start = 1'b1; s_deg = 2'd3; s_dir = 1'b0;
        tick();
        s_start = 1'b0;
        for (int b = 0; b < SB; b++) begin
            chk("s_fill_addr", s_fill, lanes(b * SL, SL));
            s_bv = 1'b1;
            tick();
        end
        s_bv = 1'b0;
        chk("s_first_src", s_src, 64'h0f0e0d0c);
        for (int p = 0; p < SN * SN; p++) begin
            chk("s_rot_valid", s_rv, 1);
            chk("s_rot_src", s_src, src_exp(SN, SCH, 3, p / SN, p % SN));
            chk("s_rot_dst", s_dst, pix_addr(SN, SCH, p / SN, p % SN));
            tick();
        end
        chk("s_rot_end", s_rv, 0);
        for (int b = 0; b < SB; b++) begin
            chk("s_drain_addr", s_drain, lanes(b * SL, SL));
            s_bv = 1'b1;
            tick();
        end
        s_bv = 1'b0;
        chk("s_done", s_done, 1);
        tick();
        chk("s_idle", s_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
